// File: rtl/alu_pkg.sv
// Shared types for the ALU and its command front-end: opcode encoding and controller FSM states.
`timescale 1ns/1ps
package alu_pkg;

    typedef logic [2:0] alu_opcode_t;

    localparam alu_opcode_t ALU_ADD  = 3'd0;
    localparam alu_opcode_t ALU_SUB  = 3'd1;
    localparam alu_opcode_t ALU_AND  = 3'd2;
    localparam alu_opcode_t ALU_OR   = 3'd3;
    localparam alu_opcode_t ALU_XOR  = 3'd4;
    localparam alu_opcode_t ALU_SHL  = 3'd5;
    localparam alu_opcode_t ALU_SHR  = 3'd6;
    localparam alu_opcode_t ALU_PASB = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_ctrl_state_t;

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU; results wrap to N bits, no flags.
// Latency: zero (purely combinational). Backpressure: none, output follows inputs.
`timescale 1ns/1ps
module alu
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   opcode,
    output logic [N-1:0] Y
);

    always_comb begin
        Y = '0;
        case (opcode)
            ALU_ADD:  Y = A + B;
            ALU_SUB:  Y = A - B;
            ALU_AND:  Y = A & B;
            ALU_OR:   Y = A | B;
            ALU_XOR:  Y = A ^ B;
            ALU_SHL:  Y = A << 1;
            ALU_SHR:  Y = A >> 1;
            ALU_PASB: Y = B;
            default:  Y = '0;
        endcase
    end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command front-end for the alu: valid/ready command in, registered operands out, result + accumulator back.
// Latency: accept -> rsp_valid 2 cycles, one op per 3 cycles. Backpressure: rsp_ready low holds RESP, cmd_ready stays 0.
// ALU_CMD_CTRL_OPCNT_EN adds a 16-bit wrapping op_count of response handshakes.
`timescale 1ns/1ps
module alu_cmd_ctrl
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_opcode,
    input  logic [N-1:0]      cmd_a,
    input  logic [N-1:0]      cmd_b,
    input  logic              cmd_use_acc,
    input  logic              acc_clr,
    output logic [N-1:0]      alu_a,
    output logic [N-1:0]      alu_b,
    output logic [2:0]        alu_opcode,
    input  logic [N-1:0]      alu_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [N-1:0]      rsp_data,
    output logic [N-1:0]      acc
`ifdef ALU_CMD_CTRL_OPCNT_EN
    ,
    output logic [15:0]       op_count
`endif
);

    alu_ctrl_state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            acc        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
`ifdef ALU_CMD_CTRL_OPCNT_EN
            op_count   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_opcode <= cmd_opcode;
                        alu_b      <= cmd_b;
                        // acc here is the pre-clear register value of this cycle
                        alu_a      <= cmd_use_acc ? acc : cmd_a;
                        cmd_ready  <= 1'b0;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_y;
                    acc       <= alu_y;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
`ifdef ALU_CMD_CTRL_OPCNT_EN
                        op_count  <= op_count + 16'd1;
`endif
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase

            // Placed last so a clear beats the EXEC capture into acc.
            if (acc_clr) begin
                acc <= '0;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl driving a real alu; responses are checked against a scoreboard queue.
`timescale 1ns/1ps
module tb_alu_cmd_ctrl;
    import alu_pkg::*;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_opcode;
    logic [N-1:0] cmd_a;
    logic [N-1:0] cmd_b;
    logic         cmd_use_acc;
    logic         acc_clr;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [2:0]   alu_opcode;
    logic [N-1:0] alu_y;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_data;
    logic [N-1:0] acc;
`ifdef ALU_CMD_CTRL_OPCNT_EN
    logic [15:0]  op_count;
`endif

    int checks = 0;
    int passed = 0;
    logic [N-1:0] sb[$];

    alu_cmd_ctrl #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_use_acc(cmd_use_acc),
        .acc_clr    (acc_clr),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_y      (alu_y),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .acc        (acc)
`ifdef ALU_CMD_CTRL_OPCNT_EN
        ,
        .op_count   (op_count)
`endif
    );

    alu #(.N(N)) u_alu (
        .A     (alu_a),
        .B     (alu_b),
        .opcode(alu_opcode),
        .Y     (alu_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command in IDLE and hold it across the accepting edge.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input alu_opcode_t op,
                         input logic ua, input logic [N-1:0] exp, input bit push);
        cmd_valid   = 1'b1;
        cmd_a       = a;
        cmd_b       = b;
        cmd_opcode  = op;
        cmd_use_acc = ua;
        if (push) sb.push_back(exp);
        check("cmd_ready_at_issue", cmd_ready, 1);
        tick();
        cmd_valid   = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        logic [N-1:0] exp;
        int n;
        n = 0;
        while (!rsp_valid && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
        if (rsp_valid && sb.size() != 0) begin
            exp = sb.pop_front();
            check({tag, "_rsp_data"}, rsp_data, exp);
        end
        rsp_ready = 1'b1;
        tick();
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_a       = '0;
        cmd_b       = '0;
        cmd_opcode  = ALU_ADD;
        cmd_use_acc = 1'b0;
        acc_clr     = 1'b0;
        rsp_ready   = 1'b1;

        // Reset values
        tick();
        tick();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_acc", acc, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_opcode", alu_opcode, 0);
        rst_n = 1'b1;
        tick();
        check("idle_cmd_ready", cmd_ready, 1);
        check("idle_rsp_valid", rsp_valid, 0);

        // Basic add with exact latency
        issue(8'd73, 8'd42, ALU_ADD, 1'b0, 8'd115, 1'b1);
        check("add_alu_a", alu_a, 73);
        check("add_alu_b", alu_b, 42);
        check("add_alu_opcode", alu_opcode, ALU_ADD);
        check("add_rsp_valid_early", rsp_valid, 0);
        check("add_cmd_ready_exec", cmd_ready, 0);
        tick();
        check("add_rsp_valid_lat2", rsp_valid, 1);
        check("add_acc", acc, 115);
        wait_rsp("add", 4);
        check("add_after_hs_rsp_valid", rsp_valid, 0);
        check("add_after_hs_cmd_ready", cmd_ready, 1);

        // Chaining through the accumulator; cmd_a must be ignored
        issue(8'hEE, 8'd10, ALU_ADD, 1'b1, 8'd125, 1'b1);
        check("chain_alu_a_from_acc", alu_a, 115);
        wait_rsp("chain", 4);
        check("chain_acc", acc, 125);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        check("chain_acc_clr", acc, 0);

        // Wrap-around with back-pressure and a competing command
        rsp_ready = 1'b0;
        issue(8'd200, 8'd100, ALU_ADD, 1'b0, 8'd44, 1'b1);
        tick();
        cmd_valid  = 1'b1;
        cmd_a      = 8'd1;
        cmd_b      = 8'd2;
        cmd_opcode = ALU_ADD;
        sb.push_back(8'd3);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_data_stable", rsp_data, 44);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_alu_a_held", alu_a, 200);
            tick();
        end
        check("bp_sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) check("bp_rsp_data", rsp_data, sb.pop_front());
        rsp_ready = 1'b1;
        tick();
        check("bp_hs_rsp_valid", rsp_valid, 0);
        check("bp_hs_cmd_ready", cmd_ready, 1);
        check("bp_not_accepted_yet", alu_a, 200);
        tick();
        cmd_valid = 1'b0;
        check("bp_second_alu_a", alu_a, 1);
        check("bp_second_alu_b", alu_b, 2);
        check("bp_second_cmd_ready", cmd_ready, 0);
        wait_rsp("bp_second", 4);

        // Clear coinciding with the EXEC capture
        issue(8'd5, 8'd3, ALU_ADD, 1'b0, 8'd8, 1'b1);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        check("clr_acc_wins", acc, 0);
        wait_rsp("clr", 4);

        // A few random adds, expected sum computed here with 8-bit wrap
        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            issue(ra, rb, ALU_ADD, 1'b0, 8'(ra + rb), 1'b1);
            wait_rsp("rand_add", 4);
        end
`ifdef ALU_CMD_CTRL_OPCNT_EN
        check("op_count_before_rst", op_count, 9);
`endif

        // Reset while a response is pending
        rsp_ready = 1'b0;
        issue(8'd9, 8'd9, ALU_ADD, 1'b0, 8'd18, 1'b0);
        tick();
        check("mid_rsp_valid", rsp_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_cmd_ready", cmd_ready, 1);
        check("arst_rsp_data", rsp_data, 0);
        check("arst_acc", acc, 0);
        check("arst_alu_a", alu_a, 0);
`ifdef ALU_CMD_CTRL_OPCNT_EN
        check("arst_op_count", op_count, 0);
`endif
        tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_no_rsp", rsp_valid, 0);
        end
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
